// File: rtl/alu_pkg.sv
// Shared opcode constants and width default for the ALU responder
// and anything that checks it.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) ||
           (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath between pipeline stages.
// Ports: a, b, op in; z result, ex zero flag, ovf signed overflow, bad_op out.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] z,
  output logic             ex,
  output logic             ovf,
  output logic             bad_op
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic             lt;

  assign sum = a + b;
  assign dif = a - b;
  assign lt  = $signed(a) < $signed(b);

  always_comb begin
    z      = '0;
    ovf    = 1'b0;
    bad_op = 1'b0;
    case (op)
      OP_AND: z = a & b;
      OP_OR:  z = a | b;
      OP_ADD: begin
        z   = sum;
        ovf = (a[MSB] == b[MSB]) &
              (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        z   = dif;
        ovf = (a[MSB] != b[MSB]) &
              (dif[MSB] != a[MSB]);
      end
      OP_SLT: z = {{(WIDTH-1){1'b0}}, lt};
      default: bad_op = 1'b1;
    endcase
  end

  assign ex = (z == '0);

endmodule

// File: rtl/alu_pipe_responder.sv
// Two-stage handshaked ALU responder: S1 holds the request, S2 the result.
// Ports: clk, reset; req_* valid/ready request in; rsp_* result out; rsp_count.
module alu_pipe_responder
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_ex,
  output logic             rsp_ovf,
  output logic             rsp_bad_op,
  output logic [CNT_W-1:0] rsp_count
);

  // live_q keeps req_ready low until the first edge after reset releases
  logic             live_q;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_z_q, s2_z_d;
  logic             s2_ex_q, s2_ex_d;
  logic             s2_ovf_q, s2_ovf_d;
  logic             s2_bad_q, s2_bad_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_free;
  logic             s1_move;
  logic             accept;
  logic             deliver;

  logic [WIDTH-1:0] c_z;
  logic             c_ex;
  logic             c_ovf;
  logic             c_bad;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a_q),
    .b      (s1_b_q),
    .op     (s1_op_q),
    .z      (c_z),
    .ex     (c_ex),
    .ovf    (c_ovf),
    .bad_op (c_bad)
  );

  assign s2_free   = !s2_valid_q | rsp_ready;
  assign s1_move   = s1_valid_q & s2_free;
  assign req_ready = live_q & (!s1_valid_q | s1_move);
  assign accept    = req_valid & req_ready;
  assign deliver   = s2_valid_q & rsp_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = req_a;
      s1_b_d     = req_b;
      s1_op_d    = req_op;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 refills on the same edge it drains
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_z_d     = s2_z_q;
    s2_ex_d    = s2_ex_q;
    s2_ovf_d   = s2_ovf_q;
    s2_bad_d   = s2_bad_q;
    if (s1_move) begin
      s2_valid_d = 1'b1;
      s2_z_d     = c_z;
      s2_ex_d    = c_ex;
      s2_ovf_d   = c_ovf;
      s2_bad_d   = c_bad;
    end else if (deliver) begin
      s2_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (deliver) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_z_q     <= '0;
      s2_ex_q    <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_bad_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      live_q     <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_z_q     <= s2_z_d;
      s2_ex_q    <= s2_ex_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_bad_q   <= s2_bad_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rsp_valid  = s2_valid_q;
  assign rsp_z      = s2_z_q;
  assign rsp_ex     = s2_ex_q;
  assign rsp_ovf    = s2_ovf_q;
  assign rsp_bad_op = s2_bad_q;
  assign rsp_count  = cnt_q;

endmodule
